// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the decoder valid/ready stage.
interface instruction_fetch_unit_if;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output imem_address,
        input  imem_instruction,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, combinational memory request, one-entry output stage towards the decoder,
// branch redirect, halt/resume and an accepted-instruction counter.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      halt_req,
    input  logic                      resume_req,
    output logic                      halted,
    output logic [31:0]               fetch_count
);

    localparam int unsigned XLEN = 32;

    // The memory decodes only the low ADDR_BITS of the address; the PC itself stays full width.
    if (ADDR_BITS == 0 || ADDR_BITS > XLEN) begin : g_addr_bits_check
        $error("instruction_fetch_unit: ADDR_BITS must be in 1..32");
    end

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   ifpc_q, ifpc_d;
    logic [XLEN-1:0]   count_q, count_d;
    logic              halted_q, halted_d;
    logic              load_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in RUN halt beats resume, in HALTED resume beats halt
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (resume_req || (redirect_valid && !halt_req)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Datapath next values: redirect flushes, otherwise load or drain the output stage
    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        count_d  = count_q;
        halted_d = (state_d == ST_HALTED);
        load_c   = (state_q == ST_RUN) && (!valid_q || bus.if_ready)
                   && !redirect_valid && !halt_req;

        if (valid_q && bus.if_ready && !redirect_valid) begin
            count_d = count_q + XLEN'(1);
        end

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else if (load_c) begin
            instr_d = bus.imem_instruction;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + XLEN'(1);
        end else if (valid_q && bus.if_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            ifpc_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    assign bus.imem_address = pc_q;
    assign bus.if_valid     = valid_q;
    assign bus.if_instr     = instr_q;
    assign bus.if_pc        = ifpc_q;
    assign halted           = halted_q;
    assign fetch_count      = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 256-word combinational instruction memory.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume_req;
    logic        halted;
    logic [31:0] fetch_count;

    int compared;
    int mismatched;

    logic [31:0] mem [256];

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .ADDR_BITS (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    assign bus.imem_instruction = mem[bus.imem_address[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h0000_0123;
        mem[1] = 32'h0000_0321;
        mem[2] = 32'd1;
        mem[3] = 32'd2;
        mem[4] = 32'd3;
        mem[5] = 32'd3;
        mem[6] = 32'd3;

        rst_n          = 1'b0;
        bus.if_ready   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        resume_req     = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_addr",   bus.imem_address, 32'h0);
        chk("rst_valid",  32'(bus.if_valid), 32'h0);
        chk("rst_instr",  bus.if_instr, 32'h0);
        chk("rst_pc",     bus.if_pc, 32'h0);
        chk("rst_count",  fetch_count, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // Streaming from reset
        rst_n        = 1'b1;
        bus.if_ready = 1'b1;
        step();
        chk("s1_instr", bus.if_instr, 32'h123);
        chk("s1_pc",    bus.if_pc, 32'd0);
        chk("s1_valid", 32'(bus.if_valid), 32'd1);
        chk("s1_addr",  bus.imem_address, 32'd1);
        step();
        chk("s2_instr", bus.if_instr, 32'h321);
        chk("s2_pc",    bus.if_pc, 32'd1);
        step();
        chk("s3_instr", bus.if_instr, 32'd1);
        chk("s3_pc",    bus.if_pc, 32'd2);
        step();
        chk("s4_instr", bus.if_instr, 32'd2);
        chk("s4_pc",    bus.if_pc, 32'd3);
        chk("s4_count", fetch_count, 32'd3);
        step();
        chk("s5_count", fetch_count, 32'd4);
        chk("s5_pc",    bus.if_pc, 32'd4);

        // Asynchronous reset between edges clears at once
        bus.if_ready = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.if_valid), 32'h0);
        chk("arst_addr",  bus.imem_address, 32'h0);
        chk("arst_count", fetch_count, 32'h0);
        chk("arst_instr", bus.if_instr, 32'h0);
        rst_n = 1'b1;

        // Backpressure holds the entry and the PC
        step();
        chk("bp_first", bus.if_instr, 32'h123);
        step();
        step();
        step();
        chk("bp_instr", bus.if_instr, 32'h123);
        chk("bp_pc",    bus.if_pc, 32'd0);
        chk("bp_valid", 32'(bus.if_valid), 32'd1);
        chk("bp_addr",  bus.imem_address, 32'd1);
        chk("bp_count", fetch_count, 32'd0);
        bus.if_ready = 1'b1;
        step();
        chk("bp_next",  bus.if_instr, 32'h321);
        chk("bp_cnt1",  fetch_count, 32'd1);

        // Redirect flushes an entry that is being accepted
        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        step();
        chk("rd_valid", 32'(bus.if_valid), 32'd0);
        chk("rd_addr",  bus.imem_address, 32'd5);
        chk("rd_count", fetch_count, 32'd1);
        redirect_valid = 1'b0;
        step();
        chk("rd_instr", bus.if_instr, 32'd3);
        chk("rd_pc",    bus.if_pc, 32'd5);
        chk("rd_cnt2",  fetch_count, 32'd1);

        // Halt with backpressure, drain, then resume
        bus.if_ready = 1'b0;
        halt_req     = 1'b1;
        step();
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_valid",  32'(bus.if_valid), 32'd1);
        chk("h_pc",     bus.if_pc, 32'd5);
        chk("h_addr",   bus.imem_address, 32'd6);
        halt_req     = 1'b0;
        bus.if_ready = 1'b1;
        step();
        chk("h_drain",  32'(bus.if_valid), 32'd0);
        chk("h_count",  fetch_count, 32'd2);
        step();
        chk("h_idle",   32'(bus.if_valid), 32'd0);
        chk("h_still",  32'(halted), 32'd1);
        resume_req = 1'b1;
        step();
        chk("r_halted", 32'(halted), 32'd0);
        chk("r_valid",  32'(bus.if_valid), 32'd0);
        resume_req = 1'b0;
        step();
        chk("r_instr",  bus.if_instr, 32'd3);
        chk("r_pc",     bus.if_pc, 32'd6);

        // Memory index aliasing above ADDR_BITS
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_00FF;
        step();
        chk("w_count0", fetch_count, 32'd2);
        redirect_valid = 1'b0;
        step();
        chk("w_instr0", bus.if_instr, 32'hA000_00FF);
        chk("w_pc0",    bus.if_pc, 32'h0000_00FF);
        step();
        chk("w_instr1", bus.if_instr, 32'h123);
        chk("w_pc1",    bus.if_pc, 32'h0000_0100);
        chk("w_count1", fetch_count, 32'd3);

        // 32-bit PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        step();
        chk("pw_pc",    bus.if_pc, 32'hFFFF_FFFF);
        chk("pw_instr", bus.if_instr, 32'hA000_00FF);
        chk("pw_addr",  bus.imem_address, 32'h0);

        // Halt and resume together in RUN: halt wins
        halt_req   = 1'b1;
        resume_req = 1'b1;
        step();
        chk("hr_halted", 32'(halted), 32'd1);
        chk("hr_addr",   bus.imem_address, 32'h0);
        halt_req   = 1'b0;
        resume_req = 1'b0;

        // Reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid",  32'(bus.if_valid), 32'h0);
        chk("mr_addr",   bus.imem_address, 32'h0);
        chk("mr_halted", 32'(halted), 32'h0);
        chk("mr_pc",     bus.if_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
